// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port synchronous RAM.
// Optional RAM_ARBITER_LOCK_EN adds req_lock so an owner can keep the grant across requests.
module ram_arbiter #(
    parameter int ADDRESS_BITS = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write,
    input  logic [2*ADDRESS_BITS-1:0] req_address,
    input  logic [2*DATA_BITS-1:0]    req_data,
`ifdef RAM_ARBITER_LOCK_EN
    input  logic [1:0]                req_lock,
`endif
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_valid,
    output logic [DATA_BITS-1:0]      rsp_data,
    output logic                      ram_write,
    output logic [ADDRESS_BITS-1:0]   ram_address,
    output logic [DATA_BITS-1:0]      ram_data_in,
    input  logic [DATA_BITS-1:0]      ram_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;
    logic                    op_write_q, op_write_d;
    logic                    ram_write_q, ram_write_d;
    logic [ADDRESS_BITS-1:0] ram_address_q, ram_address_d;
    logic [DATA_BITS-1:0]    ram_data_in_q, ram_data_in_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0]    rsp_data_q, rsp_data_d;
`ifdef RAM_ARBITER_LOCK_EN
    logic                    lock_q, lock_d;
`endif

    logic grant_valid;
    logic grant_idx;

    // Arbitration is gated by reset so nothing looks accepted while reset is held.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        if (reset && state_q == IDLE) begin
            case (req_valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_idx   = ~last_grant_q;
`ifdef RAM_ARBITER_LOCK_EN
                    if (lock_q) grant_idx = owner_q;
`endif
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_idx   = 1'b0;
                end
            endcase
        end
    end

    assign req_ready = grant_valid ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        op_write_d    = op_write_q;
        ram_write_d   = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
`ifdef RAM_ARBITER_LOCK_EN
        lock_d        = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    ram_address_d = grant_idx ? req_address[2*ADDRESS_BITS-1:ADDRESS_BITS]
                                              : req_address[ADDRESS_BITS-1:0];
                    ram_data_in_d = grant_idx ? req_data[2*DATA_BITS-1:DATA_BITS]
                                              : req_data[DATA_BITS-1:0];
                    ram_write_d   = req_write[grant_idx];
                    op_write_d    = req_write[grant_idx];
                    owner_d       = grant_idx;
                    last_grant_d  = grant_idx;
                    state_d       = ACCESS;
`ifdef RAM_ARBITER_LOCK_EN
                    lock_d        = req_lock[grant_idx];
`endif
                end
`ifdef RAM_ARBITER_LOCK_EN
                else if (lock_q && !req_valid[owner_q]) begin
                    lock_d = 1'b0;
                end
`endif
            end
            ACCESS: begin
                if (op_write_q) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_data_d           = ram_data_out;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            op_write_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
`ifdef RAM_ARBITER_LOCK_EN
            lock_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            op_write_q    <= op_write_d;
            ram_write_q   <= ram_write_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
`ifdef RAM_ARBITER_LOCK_EN
            lock_q        <= lock_d;
`endif
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign ram_write   = ram_write_q;
    assign ram_address = ram_address_q;
    assign ram_data_in = ram_data_in_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port synchronous `ram` block. Its RAM-side port list matches `ram`'s: `write`, `address`, `data_in`, `data_out`.
- Accepts read/write requests over valid/ready handshakes and arbitrates round-robin.
- Drives the RAM for exactly one access at a time and returns a response pulse to the requester that issued it.
- RAM contract: samples write/address/data_in on the rising clock edge; data_out holds the word at the sampled address after that edge.

Parameters:
ADDRESS_BITS, 4, RAM address width
DATA_BITS, 8, RAM word width

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  2  request valid, bit i = requester i
req_write  input  2  1 = write, 0 = read, per requester
req_address  input  2*ADDRESS_BITS  requester i at [i*ADDRESS_BITS +: ADDRESS_BITS]
req_data  input  2*DATA_BITS  write data, requester i at [i*DATA_BITS +: DATA_BITS]
req_ready  output  2  one-hot or zero; bit i = request i accepted this edge
rsp_valid  output  2  one-cycle response pulse to requester i
rsp_data  output  DATA_BITS  read data, valid with rsp_valid on a read
ram_write  output  1  to RAM write
ram_address  output  ADDRESS_BITS  to RAM address
ram_data_in  output  DATA_BITS  to RAM data_in
ram_data_out  input  DATA_BITS  from RAM data_out

Behaviour:
- States: IDLE, ACCESS, CAPTURE. Registers: state, last_grant, op_owner, op_write, ram_* outputs, rsp_valid, rsp_data.
- Reset (reset==0 at an edge):
  - state=IDLE, last_grant=1 (requester 0 wins first tie).
  - ram_write=0, ram_address=0, ram_data_in=0, rsp_valid=0, rsp_data=0.
  - Any in-flight operation is dropped with no response.
- req_ready is combinational and nonzero only in IDLE:
  - One requester valid: that requester gets ready.
  - Both valid: the requester != last_grant gets ready.
- Requesters hold valid, write, address and data stable until ready. Dropping valid before ready is legal and withdraws the request.
- IDLE, edge with accept of requester g:
  - Register ram_address/ram_data_in from requester g.
  - ram_write = req_write[g].
  - op_owner=g, last_grant=g, state -> ACCESS.
- ACCESS, next edge: the RAM performs the access.
  - ram_write -> 0, so a write pulse is exactly one cycle.
  - Write: rsp_valid[owner]=1 for the following cycle, rsp_data unchanged, state -> IDLE.
  - Read: state -> CAPTURE.
- CAPTURE, next edge: rsp_data <= ram_data_out, rsp_valid[owner]=1 for one cycle, state -> IDLE.
- rsp_valid is always a single-cycle pulse and at most one bit is high.
- Latency from the accept edge: write response after 1 edge, read response after 2 edges. A new accept may occur in the same cycle rsp_valid is high.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- ram_address and ram_data_in hold their last values when idle. ram_write is 0 everywhere except the ACCESS cycle of a write.
- No starvation: with both requesters continuously valid, grants strictly alternate.

Optional Feature:
- Macro: RAM_ARBITER_LOCK_EN.
- Defined:
  - Adds input `req_lock` (2 bits).
  - If the accepted requester had req_lock[g]=1 at accept, a lock flag is set.
  - At the next IDLE arbitration, if the locked owner is valid, it wins regardless of last_grant.
  - The lock clears on any accept with req_lock[g]=0, or when the owner is not valid in IDLE.
  - Reset clears the lock.
- Undefined: the port is absent; pure round-robin.

Test Plan:
- Reset: hold reset=0 for 2 edges with req_valid=2'b11 -> req_ready=0 during reset; all outputs 0; after release, requester 0 granted first.
- Single write/read:
  - Requester 0 writes addr 3, data 8'hA5 -> ram_write high exactly one cycle with address 3, rsp_valid=2'b01 one cycle after that.
  - Requester 0 then reads addr 3 -> rsp_valid=2'b01, rsp_data=8'hA5, two edges after accept.
- Contention: both continuously valid for 4 requests each -> grant order 0,1,0,1,… and no rsp_valid overlap.
- Withdrawal: requester 1 raises valid during ACCESS, then drops it before IDLE -> no grant, no RAM access, no response for requester 1.
- Reset mid-read: assert reset=0 in CAPTURE -> no rsp_valid, state IDLE, RAM contents previously written still readable afterward.
- Lock (with RAM_ARBITER_LOCK_EN): requester 1 holds req_lock=1 for 3 requests while requester 0 is valid -> grants 1,1,1, then 0.
